seg_scan_controller: RTL and testbench
======================================

# seg_scan_controller

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It owns the digit-select sequencing: slot timing, inter-digit blanking, hex-to-segment decoding and per-digit enables. It also provides a tear-free, handshaked load path, so the note/score logic can post a new 16-bit value at any time without glitching the display. It sits between the note/score logic and the display pins.

## Interface
- TICK_DIV, 50000: Clock cycles per digit slot (blank + show); must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 1000: cycles per slot with all anodes off (anti-ghosting); must be ≥ 1.
- Clock  in  1  single system clock, rising-edge.
- Reset_n  in  1  reset, asynchronous assert, active-low.
- LoadValid  in  1  producer offers LoadData/LoadDp this cycle.
- LoadReady  out  1  controller can accept a load this cycle.
- LoadData  in  16  four hex digits; [3:0] is digit 0 (rightmost).
- LoadDp  in  4  decimal point per digit, 1 = lit.
- DigitEnable  in  4  live per-digit enable, 1 = digit may light; sampled every cycle.
- Anode  out  4  active-low digit drives, one-hot-low or all high.
- Segments  out  7  active-low {g,f,e,d,c,b,a}.
- Dp  out  1  active-low decimal point.
- Selector  out  2  index of the current slot, 0..3.

## Operation
- Registers:
  - shadow (16+4 bits) plus a pending flag.
  - active (16+4 bits).
  - slot counter, sized to hold TICK_DIV-1.
  - Selector.
  - state.
- FSM, two states:
  - BLANK, entered at slot start: Anode=4'hF, Segments=7'h7F, Dp=1. Leaves to SHOW when the slot counter reaches BLANK_CYCLES-1.
  - SHOW: Anode[Selector]=0, others 1, unless DigitEnable[Selector]=0, in which case Anode=4'hF. Segments = hex decode of active digit[Selector]; Dp = ~active Dp[Selector].
  - At slot counter = TICK_DIV-1: counter→0, Selector→Selector+1 (3 wraps to 0), state→BLANK.
- Hex decode, active-low:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78.
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex).
- Load handshake:
  - LoadReady = ~pending.
  - A transfer occurs when LoadValid & LoadReady are both high on an edge: LoadData/LoadDp are captured into shadow, and pending→1.
  - LoadValid without LoadReady: no effect. The producer must hold its data until accepted.
- Frame commit:
  - A frame boundary is the edge where Selector wraps 3→0.
  - On that edge, if pending=1: active←shadow, pending→0.
  - Display content therefore changes only between frames; no frame mixes old and new digits.
- Simultaneous load and boundary: cannot coincide with pending=1 (LoadReady=0). With pending=0, the load is captured and commits at the next boundary, not this one.
- Reset, async on Reset_n low; all outputs are valid while reset is held:
  - Selector=0, state=BLANK, counter=0.
  - active=0, shadow=0, pending=0, LoadReady=1.
  - Anode=4'hF, Segments=7'h7F, Dp=1.
- Reset mid-slot or mid-handshake: a pending shadow is discarded and the display blanks immediately.
- Reset release: the first slot (Selector=0) starts BLANK on the first edge after deassertion.

## Timing
- All outputs are registered and update on the same edge as the state/counter change that causes them.
- Slot length is exactly TICK_DIV cycles, of which:
  - BLANK: exactly BLANK_CYCLES cycles.
  - SHOW: exactly TICK_DIV-BLANK_CYCLES cycles.
- Frame length is 4·TICK_DIV cycles.
- Load acceptance is 0 cycles: LoadReady is combinational from pending, and capture happens on the accepting edge.
- Load to visible: from 1 cycle up to 4·TICK_DIV cycles (next frame boundary), plus BLANK_CYCLES before digit 0 lights.
- LoadReady returns high on the edge following the commit edge's update, i.e. visible in the cycle after the boundary.
- A DigitEnable change takes effect on Anode at the next edge.

## Test plan
All scenarios use TICK_DIV=8, BLANK_CYCLES=2.
- Reset: hold Reset_n=0 mid-SHOW → Anode=F, Segments=7F, Dp=1, Selector=0, LoadReady=1 asynchronously; after release, Anode stays F for 2 cycles, then Anode=E for 6 cycles.
- Scan order: LoadData=16'h1234, LoadDp=4'b0001, all enables on → per frame, SHOW shows:
  - Anode E: Segments 19 (4), Dp=0.
  - Anode D: Segments 30 (3).
  - Anode B: Segments 24 (2).
  - Anode 7: Segments 79 (1).
  - Selector counts 0,1,2,3,0 every 8 cycles.
- Tear-free commit: display 1234 running, load 16'hABCD mid-slot 2 → digits 2 and 3 still show 2 and 1 in that frame; from the next frame digit0=21 (d) and digit3=08 (A). LoadReady is low from acceptance until the boundary.
- Back-pressure: two back-to-back loads 16'h1111 then 16'h2222 with LoadValid held → second is stalled until the boundary, committed one frame later. The 16'h1111 frame is displayed exactly once.
- DigitEnable=4'b1010 → Anode never drives 0 on digits 0 and 2; their slot timing is unchanged (blank for the full 8 cycles).
- Full decode: load each hex value 0..F on digit 0 across 16 frames → Segments match the table above in every SHOW.

Source files
------------

// File: rtl/seg_scan_controller_if.sv
// Load channel between the note/score logic and the scan controller.
// Producer holds LoadData/LoadDp with LoadValid until LoadReady is seen.
interface seg_scan_controller_if;
  logic        LoadValid;
  logic        LoadReady;
  logic [15:0] LoadData;
  logic [3:0]  LoadDp;

  modport master (
    output LoadValid,
    output LoadData,
    output LoadDp,
    input  LoadReady
  );

  modport slave (
    input  LoadValid,
    input  LoadData,
    input  LoadDp,
    output LoadReady
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Four-digit common-anode scan controller with blanking,
// hex decode, per-digit enables and a frame-synchronous load path.
module seg_scan_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  seg_scan_controller_if.slave load,
  input  logic [3:0] DigitEnable,
  output logic [3:0] Anode,
  output logic [6:0] Segments,
  output logic       Dp,
  output logic [1:0] Selector
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic [1:0]  nxt_sel;
  logic        run;
  logic        pending;
  logic [15:0] shadow;
  logic [3:0]  shadow_dp;
  logic [15:0] active;
  logic [3:0]  active_dp;
  logic [15:0] nxt_active;
  logic [3:0]  nxt_active_dp;
  logic        slot_end;
  logic        frame_end;
  logic        commit;
  logic        take;
  logic [3:0]  digit;
  logic        lit;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign load.LoadReady = ~pending;

  always_comb begin
    slot_end  = run && (cnt == SLOT_LAST);
    frame_end = slot_end && (Selector == 2'd3);
    commit    = frame_end && pending;
    take      = load.LoadValid && !pending;

    nxt_cnt       = cnt;
    nxt_sel       = Selector;
    nxt_state     = state;
    nxt_active    = active;
    nxt_active_dp = active_dp;

    // The first edge after reset release only starts slot 0.
    if (run) begin
      if (slot_end) begin
        nxt_cnt   = '0;
        nxt_sel   = Selector + 2'd1;
        nxt_state = BLANK;
      end else begin
        nxt_cnt = cnt + CW'(1);
        if (state == BLANK && cnt == BLANK_LAST)
          nxt_state = SHOW;
      end
    end

    if (commit) begin
      nxt_active    = shadow;
      nxt_active_dp = shadow_dp;
    end

    digit = nxt_active[{nxt_sel, 2'b00} +: 4];
    lit   = (nxt_state == SHOW) && DigitEnable[nxt_sel];
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      run       <= 1'b0;
      state     <= BLANK;
      cnt       <= '0;
      Selector  <= 2'd0;
      active    <= '0;
      active_dp <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
      Anode     <= 4'hF;
      Segments  <= 7'h7F;
      Dp        <= 1'b1;
    end else begin
      run       <= 1'b1;
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      Selector  <= nxt_sel;
      active    <= nxt_active;
      active_dp <= nxt_active_dp;

      // A load can never meet a commit: pending blocks LoadReady.
      if (commit) begin
        pending <= 1'b0;
      end else if (take) begin
        shadow    <= load.LoadData;
        shadow_dp <= load.LoadDp;
        pending   <= 1'b1;
      end

      Anode <= lit ? ~(4'b0001 << nxt_sel) : 4'hF;

      if (nxt_state == SHOW) begin
        Segments <= hex7(digit);
        Dp       <= ~nxt_active_dp[nxt_sel];
      end else begin
        Segments <= 7'h7F;
        Dp       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a cycle-level
// reference model and hand-computed spot checks.
module tb_seg_scan_controller;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * TD;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] DigitEnable;
  logic [3:0] Anode;
  logic [6:0] Segments;
  logic       Dp;
  logic [1:0] Selector;

  seg_scan_controller_if lif ();

  seg_scan_controller #(
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .load       (lif.slave),
    .DigitEnable(DigitEnable),
    .Anode      (Anode),
    .Segments   (Segments),
    .Dp         (Dp),
    .Selector   (Selector)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference: time since reset release fixes slot and phase;
  // content is whatever was committed at the last frame boundary.
  bit          m_run  = 1'b0;
  int          m_c    = 0;
  bit          m_pend = 1'b0;
  logic [15:0] m_act  = '0;
  logic [3:0]  m_adp  = '0;
  logic [15:0] m_sh   = '0;
  logic [3:0]  m_shdp = '0;
  logic [3:0]  m_en   = 4'hF;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_run  <= 1'b0;
      m_c    <= 0;
      m_pend <= 1'b0;
      m_act  <= '0;
      m_adp  <= '0;
      m_sh   <= '0;
      m_shdp <= '0;
      m_en   <= DigitEnable;
    end else begin
      m_en  <= DigitEnable;
      m_run <= 1'b1;
      if (m_run)
        m_c <= m_c + 1;
      if (m_run && (m_c % FR) == FR - 1 && m_pend) begin
        m_act  <= m_sh;
        m_adp  <= m_shdp;
        m_pend <= 1'b0;
      end else if (lif.LoadValid && !m_pend) begin
        m_sh   <= lif.LoadData;
        m_shdp <= lif.LoadDp;
        m_pend <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    int s;
    int ph;
    logic [3:0] dig;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    s  = 0;
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (m_run) begin
      s  = (m_c / TD) % 4;
      ph = m_c % TD;
      if (ph >= BC) begin
        dig = m_act[4*s +: 4];
        es  = seg_tab[dig];
        ed  = !m_adp[s];
        if (m_en[s])
          ea[s] = 1'b0;
      end
    end
    chk("model_anode", 16'(Anode), 16'(ea));
    chk("model_segments", 16'(Segments), 16'(es));
    chk("model_dp", 16'(Dp), 16'(ed));
    chk("model_selector", 16'(Selector), 16'(s));
    chk("model_ready", 16'(lif.LoadReady), 16'(!m_pend));
  end

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(m_run && (m_c % FR) == pos) && n < 3 * FR);
    n_chk++;
    if (!(m_run && (m_c % FR) == pos)) begin
      n_fail++;
      $display("FAIL wait_pos: got timeout, expected pos %0d", pos);
    end
  endtask

  task automatic wait_commit();
    int n;
    n = 0;
    while (m_pend && n < 3 * FR) begin
      @(negedge Clock);
      n++;
    end
    n_chk++;
    if (m_pend) begin
      n_fail++;
      $display("FAIL wait_commit: got timeout, expected commit");
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    int n;
    n = 0;
    @(negedge Clock);
    lif.LoadValid = 1'b1;
    lif.LoadData  = d;
    lif.LoadDp    = p;
    while (!lif.LoadReady && n < 3 * FR) begin
      @(negedge Clock);
      n++;
    end
    n_chk++;
    if (!lif.LoadReady) begin
      n_fail++;
      $display("FAIL load_ready: got timeout, expected accept");
    end
    @(negedge Clock);
    lif.LoadValid = 1'b0;
  endtask

  initial begin
    int n;
    lif.LoadValid = 1'b0;
    lif.LoadData  = '0;
    lif.LoadDp    = '0;
    DigitEnable   = 4'hF;

    repeat (3) @(negedge Clock);
    chk("rst_anode", 16'(Anode), 16'h000F);
    chk("rst_segments", 16'(Segments), 16'h007F);
    chk("rst_dp", 16'(Dp), 16'h0001);
    chk("rst_selector", 16'(Selector), 16'h0000);
    chk("rst_ready", 16'(lif.LoadReady), 16'h0001);

    Reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge Clock);
      if (i < 2 || i == 8) begin
        chk("rel_anode_blank", 16'(Anode), 16'h000F);
      end else begin
        chk("rel_anode_show", 16'(Anode), 16'h000E);
        chk("rel_seg_zero", 16'(Segments), 16'h0040);
      end
    end

    // Scan order with 1234, dp on digit 0
    do_load(16'h1234, 4'b0001);
    wait_commit();
    wait_pos(3);
    chk("scan0_anode", 16'(Anode), 16'h000E);
    chk("scan0_seg", 16'(Segments), 16'h0019);
    chk("scan0_dp", 16'(Dp), 16'h0000);
    wait_pos(11);
    chk("scan1_anode", 16'(Anode), 16'h000D);
    chk("scan1_seg", 16'(Segments), 16'h0030);
    chk("scan1_dp", 16'(Dp), 16'h0001);
    wait_pos(19);
    chk("scan2_anode", 16'(Anode), 16'h000B);
    chk("scan2_seg", 16'(Segments), 16'h0024);
    wait_pos(27);
    chk("scan3_anode", 16'(Anode), 16'h0007);
    chk("scan3_seg", 16'(Segments), 16'h0079);
    chk("scan3_sel", 16'(Selector), 16'h0003);

    // Tear-free: load ABCD in slot 2, old digits finish the frame
    wait_pos(17);
    do_load(16'hABCD, 4'b0000);
    chk("tear_ready_low", 16'(lif.LoadReady), 16'h0000);
    wait_pos(27);
    chk("tear_old_d3", 16'(Segments), 16'h0079);
    wait_pos(3);
    chk("tear_new_d0", 16'(Segments), 16'h0021);
    chk("tear_ready_back", 16'(lif.LoadReady), 16'h0001);
    wait_pos(27);
    chk("tear_new_d3", 16'(Segments), 16'h0008);

    // Back-pressure: 1111 then 2222 with LoadValid held
    wait_pos(5);
    lif.LoadValid = 1'b1;
    lif.LoadData  = 16'h1111;
    lif.LoadDp    = 4'b0000;
    @(negedge Clock);
    lif.LoadData = 16'h2222;
    chk("bp_stalled", 16'(lif.LoadReady), 16'h0000);
    n = 0;
    while (!lif.LoadReady && n < 3 * FR) begin
      @(negedge Clock);
      n++;
    end
    chk("bp_ready_boundary", 16'(lif.LoadReady), 16'h0001);
    @(negedge Clock);
    lif.LoadValid = 1'b0;
    wait_pos(3);
    chk("bp_first_frame", 16'(Segments), 16'h0079);
    wait_pos(3);
    chk("bp_second_frame", 16'(Segments), 16'h0024);

    // Enables 1010: digits 0 and 2 stay dark
    @(negedge Clock);
    DigitEnable = 4'b1010;
    wait_pos(4);
    chk("en_d0_dark", 16'(Anode), 16'h000F);
    wait_pos(12);
    chk("en_d1_lit", 16'(Anode), 16'h000D);
    wait_pos(20);
    chk("en_d2_dark", 16'(Anode), 16'h000F);
    wait_pos(28);
    chk("en_d3_lit", 16'(Anode), 16'h0007);
    @(negedge Clock);
    DigitEnable = 4'hF;

    // Full decode on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load(16'(v), 4'b0000);
      wait_commit();
      wait_pos(3);
    end
    chk("dec_f", 16'(Segments), 16'h000E);

    // Reset mid-SHOW with a pending load discards it
    wait_pos(2);
    do_load(16'h5678, 4'b1111);
    wait_pos(12);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_anode", 16'(Anode), 16'h000F);
    chk("arst_segments", 16'(Segments), 16'h007F);
    chk("arst_dp", 16'(Dp), 16'h0001);
    chk("arst_selector", 16'(Selector), 16'h0000);
    chk("arst_ready", 16'(lif.LoadReady), 16'h0001);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    wait_pos(3);
    chk("arst_zero_d0", 16'(Segments), 16'h0040);
    wait_pos(3);
    chk("arst_no_commit", 16'(Segments), 16'h0040);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
